// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: sequencing handshake between the pipeline controller, the datapath and data memory.
interface pipeline_ctrl_if;
  logic fwd_stall;
  logic br_taken;
  logic mem_op;
  logic dmem_ready;
  logic dmem_req;
  logic pc_en;
  logic mw_en;
  logic bubble_mw;
  logic load_valid;
  modport master (
    input  fwd_stall, br_taken, mem_op, dmem_ready,
    output dmem_req, pc_en, mw_en, bubble_mw, load_valid
  );
  modport slave (
    output fwd_stall, br_taken, mem_op, dmem_ready,
    input  dmem_req, pc_en, mw_en, bubble_mw, load_valid
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: PC/MW sequencing for the DE/MW pipeline, stretching it for memory waits, branch flushes and load-use stalls.
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  pipeline_ctrl_if.master bus,
  output logic mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0] state
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} state_t;
  state_t state_q, state_n;
  logic [3:0] flush_left;
  logic [7:0] wait_cnt, wait_n;
  logic wait_on, resolve, stall_inc, flush_inc, flush_ld;
  logic req, pc, mw, bub, lv;
  assign state = state_q;
  assign wait_n = state_q == RUN ? 8'd1 : wait_cnt == 8'hff ? wait_cnt : wait_cnt + 8'd1;
  always_comb begin
    state_n = RUN;
    req = 1'b0;
    pc = 1'b0;
    mw = 1'b1;
    bub = 1'b1;
    lv = 1'b0;
    wait_on = 1'b0;
    resolve = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    flush_ld = 1'b0;
    case (state_q)
      RUN: begin
        wait_on = bus.mem_op && !bus.dmem_ready;
        resolve = !wait_on;
      end
      MEM_WAIT: begin
        wait_on = !bus.dmem_ready;
        resolve = bus.dmem_ready;
      end
      FLUSH: state_n = flush_left > 4'd1 ? FLUSH : RUN;
      default: state_n = RUN;
    endcase
    if (wait_on) begin
      state_n = MEM_WAIT;
      req = 1'b1;
      mw = 1'b0;
      stall_inc = 1'b1;
    end
    // Completed access (or none pending): branch, then load-use, then normal flow.
    if (resolve) begin
      lv = bus.mem_op || state_q == MEM_WAIT;
      req = lv;
      if (bus.br_taken) begin
        pc = 1'b1;
        flush_inc = 1'b1;
        flush_ld = FLUSH_CYCLES > 1;
        state_n = flush_ld ? FLUSH : RUN;
      end else if (bus.fwd_stall) begin
        stall_inc = 1'b1;
      end else begin
        pc = 1'b1;
        bub = 1'b0;
      end
    end
  end
  assign bus.dmem_req = !rst && req;
  assign bus.pc_en = !rst && pc;
  assign bus.mw_en = rst || mw;
  assign bus.bubble_mw = rst || bub;
  assign bus.load_valid = !rst && lv;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      flush_left <= '0;
      wait_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      state_q <= state_n;
      flush_left <= flush_ld ? 4'(FLUSH_CYCLES - 1) :
                    (state_q == FLUSH && flush_left != 4'd0) ? flush_left - 4'd1 : flush_left;
      if (wait_on) wait_cnt <= wait_n;
      mem_err <= mem_err || (wait_on && wait_n >= 8'(MAX_WAIT));
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench comparing pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;
  localparam int FC = 3;
  localparam int MW = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst;
  logic mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0] state;
  pipeline_ctrl_if bus();
  pipeline_ctrl #(.FLUSH_CYCLES(FC), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic req, pc, mw, bub, lv, err;
    logic [1:0] st;
    logic [CW-1:0] sc, fc;
  } obs_t;
  obs_t q[$];
  int total = 0, bad = 0;
  int m_mode = 0, m_wait = 0, m_left = 0, m_stalls = 0, m_flushes = 0;
  bit m_err = 1'b0;
  task automatic expect_cycle(input bit r, m, d, b, f);
    obs_t e;
    e.req = 1'b0; e.pc = 1'b0; e.mw = 1'b1; e.bub = 1'b1; e.lv = 1'b0;
    e.err = m_err; e.st = 2'(m_mode); e.sc = CW'(m_stalls); e.fc = CW'(m_flushes);
    if (r) begin
      m_mode = 0; m_wait = 0; m_left = 0; m_stalls = 0; m_flushes = 0; m_err = 1'b0;
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end else if (!d && (m || m_mode == 1)) begin
      e.req = 1'b1; e.mw = 1'b0;
      m_wait = m_mode == 1 ? m_wait + 1 : 1;
      if (m_wait >= MW) m_err = 1'b1;
      if (m_stalls < SAT) m_stalls++;
      m_mode = 1;
    end else begin
      e.lv = m || m_mode == 1;
      e.req = e.lv;
      m_mode = 0;
      if (b) begin
        e.pc = 1'b1;
        if (m_flushes < SAT) m_flushes++;
        if (FC > 1) begin m_mode = 2; m_left = FC - 1; end
      end else if (f) begin
        if (m_stalls < SAT) m_stalls++;
      end else begin
        e.pc = 1'b1; e.bub = 1'b0;
      end
    end
    q.push_back(e);
  endtask
  task automatic step(input bit r, m, d, b, f);
    @(negedge clk);
    rst = r; bus.mem_op = m; bus.dmem_ready = d; bus.br_taken = b; bus.fwd_stall = f;
    expect_cycle(r, m, d, b, f);
  endtask
  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    obs_t e, a;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {bus.dmem_req, bus.pc_en, bus.mw_en, bus.bubble_mw, bus.load_valid, mem_err, state, stall_cnt, flush_cnt};
      if (!e.mw) a.bub = e.bub;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle_outputs t=%0t got req=%b pc=%b mw=%b bub=%b lv=%b err=%b st=%0d sc=%0d fc=%0d want req=%b pc=%b mw=%b bub=%b lv=%b err=%b st=%0d sc=%0d fc=%0d",
          $time, a.req, a.pc, a.mw, a.bub, a.lv, a.err, a.st, a.sc, a.fc,
          e.req, e.pc, e.mw, e.bub, e.lv, e.err, e.st, e.sc, e.fc);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    rst = 1'b1; bus.mem_op = 1'b0; bus.dmem_ready = 1'b0; bus.br_taken = 1'b0; bus.fwd_stall = 1'b0;
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    #3;
    check("rst_pc_en", bus.pc_en, 0);
    check("rst_bubble", bus.bubble_mw, 1);
    check("rst_dmem_req", bus.dmem_req, 0);
    step(0, 0, 0, 0, 0);
    #3;
    check("rel_state", state, 0);
    check("rel_stall_cnt", stall_cnt, 0);
    check("rel_flush_cnt", flush_cnt, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    #3;
    check("load3_stall_cnt", stall_cnt, 3);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    #3;
    check("branch_back_in_run", state, 0);
    check("branch_flush_cnt", flush_cnt, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    #3;
    check("loaduse_stall_cnt", stall_cnt, 1);
    check("loaduse_next_pc_en", bus.pc_en, 1);
    step(1, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 1, 1);
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    #3;
    check("combo_flush_cnt", flush_cnt, 1);
    check("combo_stall_cnt", stall_cnt, 2);
    step(1, 0, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0, 0);
    #3;
    check("timeout_mem_err", mem_err, 1);
    step(1, 1, 0, 0, 0);
    #3;
    check("rst_midwait_req", bus.dmem_req, 0);
    step(0, 0, 0, 0, 0);
    #3;
    check("rst_clears_err", mem_err, 0);
    repeat (2000)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6,
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    #3;
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
